// File: rtl/dmem_responder.sv
// Data-memory responder for a pipeline MEM stage: latches one request, waits a
// configurable number of cycles, then pulses ready with load data or a misalign flag.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_ctrl,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic [1:0]  o_dbg_state
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Handshake: req is held by the requester until ready; ready is a one-cycle
  // strobe and rdata/misalign are meaningful only while ready=1 (zero otherwise).
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_mem_w;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_ctrl;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic             w_direct;
  logic             w_mem_w;
  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic [2:0]       w_ctrl;
  logic             w_go_resp;
  logic [IDX_W-1:0] w_idx;
  logic [31:0]      w_word;
  logic [15:0]      w_half;
  logic [7:0]       w_byte;
  logic             w_misalign;
  logic [31:0]      w_load;
  logic [3:0]       w_be;
  logic [31:0]      w_wr_data;
  logic [31:0]      w_merged;
  logic             w_we;

  // With zero wait the access completes on the accepting edge, so it must use
  // the live inputs; otherwise the latched copy shields it from input changes.
  assign w_direct  = (r_state == S_IDLE);
  assign w_mem_w   = w_direct ? mem_w   : r_mem_w;
  assign w_addr    = w_direct ? addr    : r_addr;
  assign w_wdata   = w_direct ? wdata   : r_wdata;
  assign w_ctrl    = w_direct ? dm_ctrl : r_ctrl;
  assign w_go_resp = rst && (((r_state == S_WAIT) && (r_cnt <= 4'd1)) ||
                             ((r_state == S_IDLE) && req && (LP_WAIT == 4'd0)));

  assign w_idx  = w_addr[IDX_W+1:2];
  assign w_word = r_mem[w_idx];
  assign w_half = w_addr[1] ? w_word[31:16] : w_word[15:0];

  always_comb begin
    w_byte = w_word[7:0];
    case (w_addr[1:0])
      2'd0:    w_byte = w_word[7:0];
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      default: w_byte = w_word[31:24];
    endcase
  end

  always_comb begin
    w_misalign = 1'b0;
    w_load     = 32'd0;
    w_be       = 4'h0;
    w_wr_data  = w_wdata;
    case (w_ctrl)
      3'b000: begin
        w_misalign = |w_addr[1:0];
        w_load     = w_word;
        w_be       = 4'hF;
      end
      3'b001, 3'b010: begin
        w_misalign = w_addr[0];
        w_load     = (w_ctrl == 3'b001) ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        w_be       = w_addr[1] ? 4'hC : 4'h3;
        w_wr_data  = {2{w_wdata[15:0]}};
      end
      3'b011, 3'b100: begin
        w_load    = (w_ctrl == 3'b011) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
        w_be      = 4'b0001 << w_addr[1:0];
        w_wr_data = {4{w_wdata[7:0]}};
      end
      default: w_misalign = 1'b1;
    endcase
  end

  always_comb begin
    w_merged = w_word;
    for (int i = 0; i < 4; i++) begin
      if (w_be[i]) w_merged[8*i +: 8] = w_wr_data[8*i +: 8];
    end
  end

  assign w_we = w_go_resp && w_mem_w && !w_misalign;

  // Array contents survive reset; an aborted access never reaches w_go_resp.
  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_idx] <= w_merged;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_mem_w  <= 1'b0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_ctrl   <= 3'd0;
      ready    <= 1'b0;
      misalign <= 1'b0;
      rdata    <= 32'd0;
    end else begin
      ready    <= 1'b0;
      misalign <= 1'b0;
      rdata    <= 32'd0;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_mem_w <= mem_w;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_ctrl  <= dm_ctrl;
            if (LP_WAIT == 4'd0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= LP_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_state <= S_RESP;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
      if (w_go_resp) begin
        ready    <= 1'b1;
        misalign <= w_misalign;
        rdata    <= (w_misalign || w_mem_w) ? 32'd0 : w_load;
      end
    end
  end

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with one wait cycle, one with
// zero wait cycles, hand-computed expectations checked by immediate assertions.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam logic [2:0] C_W  = 3'b000;
  localparam logic [2:0] C_H  = 3'b001;
  localparam logic [2:0] C_HU = 3'b010;
  localparam logic [2:0] C_B  = 3'b011;
  localparam logic [2:0] C_BU = 3'b100;
  localparam logic [2:0] C_RS = 3'b101;

  logic        clk;
  logic        rst;
  logic        d1_req, d1_mem_w, d1_ready, d1_misalign;
  logic [31:0] d1_addr, d1_wdata, d1_rdata;
  logic [2:0]  d1_ctrl;
  logic [1:0]  d1_state;
  logic        d0_req, d0_mem_w, d0_ready, d0_misalign;
  logic [31:0] d0_addr, d0_wdata, d0_rdata;
  logic [2:0]  d0_ctrl;
  logic [1:0]  d0_state;

  int n_chk = 0;
  int n_err = 0;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(d1_req), .mem_w(d1_mem_w), .addr(d1_addr),
    .wdata(d1_wdata), .dm_ctrl(d1_ctrl), .ready(d1_ready), .rdata(d1_rdata),
    .misalign(d1_misalign), .o_dbg_state(d1_state)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .req(d0_req), .mem_w(d0_mem_w), .addr(d0_addr),
    .wdata(d0_wdata), .dm_ctrl(d0_ctrl), .ready(d0_ready), .rdata(d0_rdata),
    .misalign(d0_misalign), .o_dbg_state(d0_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request, holds req until ready, then checks the response and
  // the idle cycle that follows it.
  task automatic access(input bit sel, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] c, input int exp_lat,
                        input logic [31:0] exp_rd, input logic exp_mis, input string tag);
    int  lat;
    bit  got;
    logic rdy, mis;
    logic [31:0] rd;
    lat = 0;
    got = 1'b0;
    rd  = 32'd0;
    mis = 1'b0;
    if (sel) begin
      d1_req = 1'b1; d1_mem_w = w; d1_addr = a; d1_wdata = d; d1_ctrl = c;
    end else begin
      d0_req = 1'b1; d0_mem_w = w; d0_addr = a; d0_wdata = d; d0_ctrl = c;
    end
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      rdy = sel ? d1_ready : d0_ready;
      if (rdy) begin
        got = 1'b1;
        rd  = sel ? d1_rdata : d0_rdata;
        mis = sel ? d1_misalign : d0_misalign;
      end
    end
    if (sel) d1_req = 1'b0; else d0_req = 1'b0;
    chk({tag, " ready_seen"}, {31'd0, got}, 32'd1);
    if (got) begin
      chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, " rdata"}, rd, exp_rd);
      chk({tag, " misalign"}, {31'd0, mis}, {31'd0, exp_mis});
      @(posedge clk); #1;
      rdy = sel ? d1_ready : d0_ready;
      rd  = sel ? d1_rdata : d0_rdata;
      mis = sel ? d1_misalign : d0_misalign;
      chk({tag, " ready_drop"}, {31'd0, rdy}, 32'd0);
      chk({tag, " idle_rdata"}, rd, 32'd0);
      chk({tag, " idle_misalign"}, {31'd0, mis}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0;
    d1_req = 1'b0; d1_mem_w = 1'b0; d1_addr = 32'd0; d1_wdata = 32'd0; d1_ctrl = C_W;
    d0_req = 1'b0; d0_mem_w = 1'b0; d0_addr = 32'd0; d0_wdata = 32'd0; d0_ctrl = C_W;
    #1;
    chk("rst ready", {31'd0, d1_ready}, 32'd0);
    chk("rst rdata", d1_rdata, 32'd0);
    chk("rst misalign", {31'd0, d1_misalign}, 32'd0);
    chk("rst state", {30'd0, d1_state}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // store / load basics, sign and zero extension
    access(1, 1, 32'h10, 32'hDEADBEEF, C_W,  2, 32'h0, 0, "sw 0x10");
    access(1, 0, 32'h10, 32'h0,        C_W,  2, 32'hDEADBEEF, 0, "lw 0x10");
    access(1, 1, 32'h13, 32'h80,       C_B,  2, 32'h0, 0, "sb 0x13");
    access(1, 0, 32'h13, 32'h0,        C_B,  2, 32'hFFFFFF80, 0, "lb 0x13");
    access(1, 0, 32'h13, 32'h0,        C_BU, 2, 32'h00000080, 0, "lbu 0x13");
    access(1, 0, 32'h10, 32'h0,        C_W,  2, 32'h80ADBEEF, 0, "lw 0x10 merged");
    access(1, 0, 32'h12, 32'h0,        C_H,  2, 32'hFFFF80AD, 0, "lh 0x12");
    access(1, 0, 32'h10, 32'h0,        C_HU, 2, 32'h0000BEEF, 0, "lhu 0x10");

    // misalignment and reserved codes
    access(1, 1, 32'h20, 32'h0BADF00D, C_W,  2, 32'h0, 0, "sw 0x20");
    access(1, 1, 32'h21, 32'h1234,     C_H,  2, 32'h0, 1, "sh 0x21 misaligned");
    access(1, 0, 32'h20, 32'h0,        C_W,  2, 32'h0BADF00D, 0, "lw 0x20 unchanged");
    access(1, 0, 32'h22, 32'h0,        C_W,  2, 32'h0, 1, "lw 0x22 misaligned");
    access(1, 0, 32'h20, 32'h0,        C_RS, 2, 32'h0, 1, "reserved code");

    // upper address bits wrap onto word 0
    access(1, 1, 32'h400, 32'h55AA55AA, C_W, 2, 32'h0, 0, "sw 0x400");
    access(1, 0, 32'h0,   32'h0,        C_W, 2, 32'h55AA55AA, 0, "lw 0x0 wrap");

    // inputs changed after acceptance do not affect the access in flight
    d1_req = 1'b1; d1_mem_w = 1'b0; d1_addr = 32'h10; d1_ctrl = C_W;
    @(posedge clk); #1;
    d1_mem_w = 1'b1; d1_addr = 32'h20; d1_wdata = 32'hFFFFFFFF; d1_ctrl = C_B;
    @(posedge clk); #1;
    chk("inflight ready", {31'd0, d1_ready}, 32'd1);
    chk("inflight rdata", d1_rdata, 32'h80ADBEEF);
    d1_req = 1'b0;
    @(posedge clk); #1;
    chk("inflight drop", {31'd0, d1_ready}, 32'd0);
    access(1, 0, 32'h20, 32'h0, C_W, 2, 32'h0BADF00D, 0, "lw 0x20 after inflight");

    // reset during WAIT aborts the store
    access(1, 1, 32'h30, 32'hCAFE0030, C_W, 2, 32'h0, 0, "sw 0x30");
    d1_req = 1'b1; d1_mem_w = 1'b1; d1_addr = 32'h30; d1_wdata = 32'h11111111; d1_ctrl = C_W;
    @(posedge clk); #1;
    chk("abort in wait", {30'd0, d1_state}, 32'd1);
    d1_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort state", {30'd0, d1_state}, 32'd0);
    chk("abort ready", {31'd0, d1_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort no ready", {31'd0, d1_ready}, 32'd0);
    end
    access(1, 0, 32'h30, 32'h0, C_W, 2, 32'hCAFE0030, 0, "lw 0x30 after abort");

    // zero-wait instance: held req gives alternating ready
    access(0, 1, 32'h40, 32'hA5A5A5A5, C_W, 1, 32'h0, 0, "d0 sw 0x40");
    access(0, 1, 32'h44, 32'h3C3C3C3C, C_W, 1, 32'h0, 0, "d0 sw 0x44");
    d0_req = 1'b1; d0_mem_w = 1'b0; d0_addr = 32'h40; d0_ctrl = C_W;
    chk("held ready c0", {31'd0, d0_ready}, 32'd0);
    for (int k = 1; k < 6; k++) begin
      @(posedge clk); #1;
      chk("held ready", {31'd0, d0_ready}, 32'(k % 2));
      if (k % 2 == 1) begin
        chk("held rdata", d0_rdata, (k == 3) ? 32'h3C3C3C3C : 32'hA5A5A5A5);
        d0_addr = (d0_addr == 32'h40) ? 32'h44 : 32'h40;
        #1;
        chk("held rdata stable", d0_rdata, (k == 3) ? 32'h3C3C3C3C : 32'hA5A5A5A5);
      end else begin
        chk("held idle rdata", d0_rdata, 32'd0);
      end
    end
    d0_req = 1'b0;
    @(posedge clk); #1;
    chk("held end ready", {31'd0, d0_ready}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
